// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array operand feeder.
package sa_pkg;

    localparam int WDATA_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_t;

    // Cycles after the last accept until the far-corner PE has consumed it.
    function automatic int flush_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/skew_chain.sv
// One lane's zero-resettable delay line; DEPTH registers from din to dout.
module skew_chain #(
    parameter int WDATA = 4,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WDATA-1:0] din,
    output logic [WDATA-1:0] dout
);

    logic [WDATA-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Skewed west/north operand feeder for an N x N systolic array.
// Optional macro FEEDER_CLR_EN: emit a one-cycle array_clr pulse at the start of each pass.
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int WDATA = WDATA_DEFAULT,
    parameter int N     = 4,
    parameter int K     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WDATA-1:0] in_a,
    input  logic [N*WDATA-1:0] in_b,
    output logic [N*WDATA-1:0] edge_w,
    output logic [N*WDATA-1:0] edge_n,
    output logic               array_clr,
    output logic               busy,
    output logic               done
);

    localparam int BEAT_W    = $clog2(K + 1);
    localparam int FLUSH_W   = $clog2(2 * N);
    localparam int FLUSH_LEN = flush_len(N);
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(K - 1);
    localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(FLUSH_LEN - 1);

    feeder_state_t        state, state_nxt;
    logic [BEAT_W-1:0]    beat_cnt, beat_nxt;
    logic [FLUSH_W-1:0]   flush_cnt, flush_nxt;
    logic                 accept;

    assign in_ready = (state == STREAM);
    assign accept   = in_ready & in_valid;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_nxt;
            flush_cnt <= flush_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        flush_nxt = flush_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = STREAM;
                    beat_nxt  = '0;
                end
            end
            STREAM: begin
                if (accept) begin
                    beat_nxt = beat_cnt + 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt = FLUSH;
                        flush_nxt = '0;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt == LAST_FLUSH) state_nxt = DONE;
                else                         flush_nxt = flush_cnt + 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Non-accept cycles inject zeros so every chain keeps shifting in lockstep.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_chain #(.WDATA(WDATA), .DEPTH(i + 1)) u_chain_w (
            .clk  (clk),
            .rst  (rst),
            .din  (accept ? in_a[i*WDATA +: WDATA] : {WDATA{1'b0}}),
            .dout (edge_w[i*WDATA +: WDATA])
        );
        skew_chain #(.WDATA(WDATA), .DEPTH(i + 1)) u_chain_n (
            .clk  (clk),
            .rst  (rst),
            .din  (accept ? in_b[i*WDATA +: WDATA] : {WDATA{1'b0}}),
            .dout (edge_n[i*WDATA +: WDATA])
        );
    end

`ifdef FEEDER_CLR_EN
    logic clr_q;

    always_ff @(posedge clk) begin
        if (rst) clr_q <= 1'b0;
        else     clr_q <= (state == IDLE) & start;
    end

    assign array_clr = clr_q;
`else
    assign array_clr = 1'b0;
`endif

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder: per-cycle edge/handshake expectations plus a downstream array model.
module tb_sa_skew_feeder;

    localparam int W    = 4;
    localparam int N    = 4;
    localparam int K    = 4;
    localparam int NW   = N * W;
    localparam int MAXC = 4096;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] in_a;
    logic [NW-1:0] in_b;
    logic [NW-1:0] edge_w;
    logic [NW-1:0] edge_n;
    logic          array_clr;
    logic          busy;
    logic          done;

    sa_skew_feeder #(.WDATA(W), .N(N), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .edge_w    (edge_w),
        .edge_n    (edge_n),
        .array_clr (array_clr),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle outputs, all zero unless a rule sets them.
    bit [NW-1:0] expw [MAXC];
    bit [NW-1:0] expn [MAXC];
    bit          exp_rdy [MAXC];
    bit          exp_busy [MAXC];
    bit          exp_clr [MAXC];

    int done_q[$];
    int res_q[$];
    int acc_exp [N][N];

    bit [W-1:0] pa [K][N];
    bit [W-1:0] pb [K][N];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Downstream PE grid: operands travel east/south one hop per cycle.
    logic [W-1:0] pw [N][N];
    logic [W-1:0] pn [N][N];
    int           acc [N][N];

    function automatic logic [W-1:0] west_in(input int r, input int c);
        return (c == 0) ? edge_w[r*W +: W] : pw[r][c-1];
    endfunction

    function automatic logic [W-1:0] north_in(input int r, input int c);
        return (r == 0) ? edge_n[c*W +: W] : pn[r-1][c];
    endfunction

    always @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (rst || array_clr) begin
                    pw[r][c]  <= '0;
                    pn[r][c]  <= '0;
                    acc[r][c] <= 0;
                end else begin
                    pw[r][c]  <= west_in(r, c);
                    pn[r][c]  <= north_in(r, c);
                    acc[r][c] <= acc[r][c] + int'(west_in(r, c)) * int'(north_in(r, c));
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            check("edge_w", 64'(edge_w), 64'(expw[cyc]));
            check("edge_n", 64'(edge_n), 64'(expn[cyc]));
            check("in_ready", 64'(in_ready), 64'(exp_rdy[cyc]));
            check("busy", 64'(busy), 64'(exp_busy[cyc]));
            check("array_clr", 64'(array_clr), 64'(exp_clr[cyc]));
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 64'(1), 64'(0));
                end else begin
                    check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++)
                            check($sformatf("pe_result[%0d][%0d]", r, c),
                                  64'(acc[r][c]), 64'(res_q.pop_front()));
                end
            end else begin
                check("done_level", 64'(done), 64'(0));
                if (done_q.size() > 0 && cyc > done_q[0]) begin
                    check("done_missing", 64'(0), 64'(1));
                    void'(done_q.pop_front());
                    for (int i = 0; i < N * N; i++) void'(res_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void mark_stream(input int c);
        if (c < MAXC) begin
            exp_rdy[c]  = 1'b1;
            exp_busy[c] = 1'b1;
        end
    endfunction

    function automatic void set_lane(input int c, input int lane, input bit [W-1:0] a, input bit [W-1:0] b);
        if (c < MAXC) begin
            expw[c][lane*W +: W] = a;
            expn[c][lane*W +: W] = b;
        end
    endfunction

    // Plain matrix product of the pass just issued, folded into the running accumulator view.
    task automatic push_expect(input int done_cyc);
        int prod;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                prod = 0;
                for (int k = 0; k < K; k++) prod += int'(pa[k][r]) * int'(pb[k][c]);
`ifdef FEEDER_CLR_EN
                acc_exp[r][c] = prod;
`else
                acc_exp[r][c] = acc_exp[r][c] + prod;
`endif
                res_q.push_back(acc_exp[r][c]);
            end
        end
        done_q.push_back(done_cyc);
    endtask

    task automatic do_reset(input int ncyc);
        for (int c = cyc + 1; c < MAXC; c++) begin
            expw[c]     = '0;
            expn[c]     = '0;
            exp_rdy[c]  = 1'b0;
            exp_busy[c] = 1'b0;
            exp_clr[c]  = 1'b0;
        end
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        repeat (ncyc) step();
        rst = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) acc_exp[r][c] = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            start    = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            in_a     = NW'($urandom);
            in_b     = NW'($urandom);
            step();
        end
        in_valid = 1'b0;
    endtask

    // gap: 0 = valid every cycle, 1 = alternate, 2 = random. abort > 0: reset after that many accepts.
    task automatic run_pass(input int gap, input bit noise, input int abort);
        int k;
        int it;
        bit v;
        bit tog;
        start    = 1'b1;
        in_valid = 1'b1;
        in_a     = NW'($urandom);
        in_b     = NW'($urandom);
`ifdef FEEDER_CLR_EN
        if (cyc + 1 < MAXC) exp_clr[cyc+1] = 1'b1;
`endif
        step();
        k   = 0;
        it  = 0;
        tog = 1'b1;
        while (k < K) begin
            mark_stream(cyc);
            if (abort > 0 && k == abort) begin
                do_reset(3);
                return;
            end
            case (gap)
                0:       v = 1'b1;
                1:       begin v = tog; tog = !tog; end
                default: v = ($urandom_range(0, 2) != 0) || (it > 40);
            endcase
            it++;
            in_valid = v;
            start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int i = 0; i < N; i++) begin
                in_a[i*W +: W] = v ? pa[k][i] : W'($urandom);
                in_b[i*W +: W] = v ? pb[k][i] : W'($urandom);
            end
            if (v) begin
                for (int i = 0; i < N; i++) set_lane(cyc + 1 + i, i, pa[k][i], pb[k][i]);
                k++;
                if (k == K) push_expect(cyc + 2 * N);
            end
            step();
        end
        for (int j = 0; j < 2 * N; j++) begin
            if (cyc < MAXC) exp_busy[cyc] = 1'b1;
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            in_a     = NW'($urandom);
            in_b     = NW'($urandom);
            start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < K; k++)
            for (int i = 0; i < N; i++) begin
                pa[k][i] = W'($urandom);
                pb[k][i] = W'($urandom);
            end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        step();
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        idle_cycles(2);

        // Diagonal A with values 1..N, structured B.
        for (int k = 0; k < K; k++)
            for (int i = 0; i < N; i++) begin
                pa[k][i] = (i == k) ? W'(i + 1) : '0;
                pb[k][i] = W'(k + i + 1);
            end
        run_pass(0, 1'b0, 0);
        run_pass(1, 1'b0, 0);

        // Lone all-ones slice followed by zero slices shows the pure skew.
        for (int k = 0; k < K; k++)
            for (int i = 0; i < N; i++) begin
                pa[k][i] = (k == 0) ? 4'hF : 4'h0;
                pb[k][i] = (k == 0) ? 4'hF : 4'h0;
            end
        run_pass(2, 1'b1, 0);
        idle_cycles(3);

        fill_random();
        run_pass(2, 1'b1, 2);
        idle_cycles(3);

        for (int p = 0; p < 8; p++) begin
            fill_random();
            run_pass(2, 1'b1, 0);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 4));
        end

        idle_cycles(6);
        check("scoreboard_drained", 64'(done_q.size()), 64'(0));
        check("run_within_budget", 64'(cyc < MAXC), 64'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
